// File: rtl/gpmc_master.sv
// GPMC bus initiator: turns single read/write commands into muxed address/data
// GPMC cycles on the CSR or DMA chip-select, with gpmc_clk = sys_clk/2.
module gpmc_master #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned WAIT_MIN = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_stb,
  output logic        cmd_ack,
  input  logic        cmd_we,
  input  logic        cmd_sel,
  input  logic [25:0] cmd_adr,
  input  logic [15:0] cmd_dat_w,
  output logic        rsp_stb,
  output logic        rsp_timeout,
  output logic [15:0] rsp_dat_r,
  output logic        gpmc_clk,
  output logic [9:0]  gpmc_a,
  output logic [15:0] gpmc_d_o,
  output logic        gpmc_d_oe,
  input  logic [15:0] gpmc_d_i,
  output logic        gpmc_ale_n,
  output logic        gpmc_we_n,
  output logic        gpmc_oe_n,
  input  logic        gpmc_wait,
  output logic        gpmc_csr_cs_n,
  output logic        gpmc_dma_cs_n
);

  // Command handshake: cmd_stb is held by the requester until the one-cycle
  // cmd_ack; rsp_stb is a one-cycle pulse qualifying rsp_timeout/rsp_dat_r.

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_ACCESS, S_RECOVER} state_t;

  localparam logic [15:0] TIMEOUT_C  = 16'(TIMEOUT);
  localparam logic [15:0] WAIT_MIN_C = 16'(WAIT_MIN);

  state_t      state_q, state_d;
  logic        gclk_q, gclk_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic        we_q, we_d;
  logic [15:0] dat_w_q, dat_w_d;
  logic [9:0]  a_q, a_d;
  logic [15:0] d_o_q, d_o_d;
  logic        d_oe_q, d_oe_d;
  logic        ale_n_q, ale_n_d;
  logic        we_n_q, we_n_d;
  logic        oe_n_q, oe_n_d;
  logic        csr_cs_n_q, csr_cs_n_d;
  logic        dma_cs_n_q, dma_cs_n_d;
  logic        cmd_ack_q, cmd_ack_d;
  logic        rsp_stb_q, rsp_stb_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [15:0] rsp_dat_q, rsp_dat_d;
  logic        fall;

  // gpmc_clk high now means this edge drives it low: the only edge we act on.
  assign fall    = gclk_q;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    gclk_d        = ~gclk_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    dat_w_d       = dat_w_q;
    a_d           = a_q;
    d_o_d         = d_o_q;
    d_oe_d        = d_oe_q;
    ale_n_d       = ale_n_q;
    we_n_d        = we_n_q;
    oe_n_d        = oe_n_q;
    csr_cs_n_d    = csr_cs_n_q;
    dma_cs_n_d    = dma_cs_n_q;
    cmd_ack_d     = 1'b0;
    rsp_stb_d     = 1'b0;
    rsp_timeout_d = rsp_timeout_q;
    rsp_dat_d     = rsp_dat_q;

    if (fall) begin
      case (state_q)
        S_IDLE, S_RECOVER: begin
          state_d = S_IDLE;
          // RECOVER may hand straight over to a new address phase.
          if (cmd_stb) begin
            we_d       = cmd_we;
            dat_w_d    = cmd_dat_w;
            cmd_ack_d  = 1'b1;
            ale_n_d    = 1'b0;
            csr_cs_n_d = cmd_sel;
            dma_cs_n_d = ~cmd_sel;
            a_d        = cmd_adr[25:16];
            d_o_d      = cmd_adr[15:0];
            d_oe_d     = 1'b1;
            state_d    = S_ADDR;
          end
        end
        S_ADDR: begin
          ale_n_d = 1'b1;
          cnt_d   = 16'd0;
          if (we_q) begin
            we_n_d = 1'b0;
            d_o_d  = dat_w_q;
            d_oe_d = 1'b1;
          end else begin
            oe_n_d = 1'b0;
            d_oe_d = 1'b0;
          end
          state_d = S_ACCESS;
        end
        S_ACCESS: begin
          cnt_d = cnt_inc;
          if ((cnt_inc >= WAIT_MIN_C) && !gpmc_wait) begin
            if (!we_q) rsp_dat_d = gpmc_d_i;
            we_n_d        = 1'b1;
            oe_n_d        = 1'b1;
            csr_cs_n_d    = 1'b1;
            dma_cs_n_d    = 1'b1;
            d_oe_d        = 1'b0;
            rsp_stb_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            state_d       = S_RECOVER;
          end else if (cnt_inc == TIMEOUT_C) begin
            we_n_d        = 1'b1;
            oe_n_d        = 1'b1;
            csr_cs_n_d    = 1'b1;
            dma_cs_n_d    = 1'b1;
            d_oe_d        = 1'b0;
            rsp_stb_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            state_d       = S_RECOVER;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= S_IDLE;
      gclk_q        <= 1'b0;
      cnt_q         <= 16'd0;
      we_q          <= 1'b0;
      dat_w_q       <= 16'd0;
      a_q           <= 10'd0;
      d_o_q         <= 16'd0;
      d_oe_q        <= 1'b0;
      ale_n_q       <= 1'b1;
      we_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      csr_cs_n_q    <= 1'b1;
      dma_cs_n_q    <= 1'b1;
      cmd_ack_q     <= 1'b0;
      rsp_stb_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_dat_q     <= 16'd0;
    end else begin
      state_q       <= state_d;
      gclk_q        <= gclk_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      dat_w_q       <= dat_w_d;
      a_q           <= a_d;
      d_o_q         <= d_o_d;
      d_oe_q        <= d_oe_d;
      ale_n_q       <= ale_n_d;
      we_n_q        <= we_n_d;
      oe_n_q        <= oe_n_d;
      csr_cs_n_q    <= csr_cs_n_d;
      dma_cs_n_q    <= dma_cs_n_d;
      cmd_ack_q     <= cmd_ack_d;
      rsp_stb_q     <= rsp_stb_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_dat_q     <= rsp_dat_d;
    end
  end

  assign cmd_ack       = cmd_ack_q;
  assign rsp_stb       = rsp_stb_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign rsp_dat_r     = rsp_dat_q;
  assign gpmc_clk      = gclk_q;
  assign gpmc_a        = a_q;
  assign gpmc_d_o      = d_o_q;
  assign gpmc_d_oe     = d_oe_q;
  assign gpmc_ale_n    = ale_n_q;
  assign gpmc_we_n     = we_n_q;
  assign gpmc_oe_n     = oe_n_q;
  assign gpmc_csr_cs_n = csr_cs_n_q;
  assign gpmc_dma_cs_n = dma_cs_n_q;

endmodule

// File: doc/gpmc_master.md
Name: gpmc_master

Overview:
- Synchronous GPMC bus initiator: the processor side of the muxed address/data GPMC protocol served by our FPGA GPMC slave.
- Converts single read/write commands from a sys_clk command port into GPMC bus cycles on the CSR or DMA chip-select.
- Used as a synthesizable bus driver for loopback and self-test builds, and as the stimulus engine in system benches of the GPMC slave.

Parameters:
- TIMEOUT, 255: max gpmc_clk periods spent in ACCESS before abort; range 1..65535.
- WAIT_MIN, 1: gpmc_clk periods in ACCESS before gpmc_wait is honoured; range 0..15.

Ports:
- sys_clk  in  1  sole clock; all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- cmd_stb  in  1  command valid; held until cmd_ack.
- cmd_ack  out  1  one-cycle pulse: command accepted.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_sel  in  1  0 = CSR chip-select, 1 = DMA chip-select.
- cmd_adr  in  26  byte address; [25:16] on gpmc_a, [15:0] on gpmc_d during address phase.
- cmd_dat_w  in  16  write data.
- rsp_stb  out  1  one-cycle pulse: access finished.
- rsp_timeout  out  1  valid with rsp_stb; 1 = aborted by TIMEOUT.
- rsp_dat_r  out  16  read data, valid with rsp_stb on non-timed-out reads; held until next rsp_stb.
- gpmc_clk  out  1  bus clock, sys_clk/2, free-running.
- gpmc_a  out  10  upper address.
- gpmc_d_o  out  16  data/address output.
- gpmc_d_oe  out  1  output enable for gpmc_d_o; the pad tristate lives at top level.
- gpmc_d_i  in  16  data input from pad.
- gpmc_ale_n  out  1  address latch enable, active low.
- gpmc_we_n  out  1  write enable, active low.
- gpmc_oe_n  out  1  output enable, active low.
- gpmc_wait  in  1  high = slave busy; low = access complete.
- gpmc_csr_cs_n  out  1  CSR chip-select, active low.
- gpmc_dma_cs_n  out  1  DMA chip-select, active low.

Behaviour:
- Clocking
  - gpmc_clk is a register that toggles every sys_clk cycle.
  - A "fall cycle" is a sys_clk edge where gpmc_clk goes 1->0.
  - All GPMC outputs, the FSM and input sampling (gpmc_wait, gpmc_d_i) update only on fall cycles. The slave samples on gpmc_clk rise; inputs get half a period of setup.
- Reset (takes effect next edge, including mid-access)
  - gpmc_clk=0; gpmc_ale_n=gpmc_we_n=gpmc_oe_n=1; both cs_n=1; gpmc_d_oe=0.
  - gpmc_a=0, gpmc_d_o=0.
  - cmd_ack=0, rsp_stb=0, rsp_timeout=0, rsp_dat_r=0.
  - FSM=IDLE, counters=0.
  - An in-flight command is dropped with no rsp_stb.
- IDLE
  - On a fall cycle with cmd_stb=1: latch the command and pulse cmd_ack.
  - Drive ale_n=0, the selected cs_n=0, gpmc_a=adr[25:16], gpmc_d_o=adr[15:0], d_oe=1. Go to ADDR.
  - cmd_stb on non-fall cycles waits; no ack.
- ADDR (1 period), next fall cycle:
  - ale_n=1.
  - Write: we_n=0, gpmc_d_o=dat_w, d_oe=1.
  - Read: oe_n=0, d_oe=0.
  - Clear period counter; go to ACCESS.
- ACCESS, each fall cycle:
  - counter+1 (saturating).
  - If counter>=WAIT_MIN and sampled gpmc_wait=0:
    - capture gpmc_d_i into rsp_dat_r if read;
    - deassert we_n/oe_n/cs_n, d_oe=0;
    - pulse rsp_stb with rsp_timeout=0; go to RECOVER.
  - Else if counter==TIMEOUT: same deassertion, rsp_timeout=1, rsp_dat_r unchanged, go to RECOVER.
  - If both hold on the same fall cycle, completion wins.
- RECOVER (1 period, all strobes inactive): next fall cycle go to IDLE. The next command may be accepted on that same fall cycle.
- cmd_ack and rsp_stb are single sys_clk cycles, never asserted together.
- At most one command is outstanding.
- cmd_sel picks exactly one cs_n; the other stays 1 throughout.
- gpmc_a and gpmc_d_o hold their last value when not meaningful.

Test Plan:
- Reset: hold sys_rst 3 cycles -> all strobes/cs_n=1, d_oe=0, gpmc_clk=0, rsp_stb=0. Release -> gpmc_clk toggles every cycle.
- CSR write, adr=0x0000123, dat=0x00A5, slave pulls wait low after 3 periods -> ADDR shows a=0x000, d=0x0123, ale_n=0, csr_cs_n=0. Then we_n=0, d=0x00A5 until wait sampled low. Exactly one rsp_stb, rsp_timeout=0. dma_cs_n stays 1.
- DMA read, adr=0x3FF0004, slave returns 0xBEEF with wait low -> gpmc_a=0x3FF during ADDR, d_oe=0 during ACCESS, rsp_dat_r=0xBEEF at rsp_stb.
- Timeout, TIMEOUT=4, wait held 1 -> rsp_stb after 4 ACCESS periods with rsp_timeout=1. Strobes release; rsp_dat_r keeps its prior value.
- Back-to-back: cmd_stb held across two commands -> second cmd_ack on the RECOVER->IDLE fall cycle. ale_n reasserts exactly one period after the first access's strobes deassert.
- Reset mid-ACCESS of a read -> next cycle all outputs at reset values, no rsp_stb, the following command runs normally.
